// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and the
// parity helper used by both ends of the link.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_CPB_W     = 10;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side byte port: holding register with valid/ack plus status flags.
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_out;
  logic                      data_valid;
  logic                      data_ack;
  logic                      parity_err;
  logic                      frame_err;
  logic                      overrun;
  logic                      busy;

  modport master (
    output data_out, data_valid, parity_err, frame_err, overrun, busy,
    input  data_ack
  );

  modport slave (
    input  data_out, data_valid, parity_err, frame_err, overrun, busy,
    output data_ack
  );
endinterface

// File: rtl/uart_sync.sv
// Flop chain bringing the asynchronous RX line into the clk domain; resets to
// the idle (high) level so reset never looks like a start bit.
module uart_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst) chain <= '1;
    else      chain <= {chain[DEPTH-2:0], d};
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, DATA_BITS LSB first, even-sum parity, stop.
// Mid-bit sampling of the synchronized line, byte delivered via valid/ack.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  UART_line,
  input  logic [UART_CPB_W-1:0] clks_per_bit,
  uart_rx_frame_if.master       bus
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic line_s;

  uart_sync #(.DEPTH(SYNC_DEPTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (UART_line),
    .q   (line_s)
  );

  uart_rx_state_t        state, state_nxt;
  logic [UART_CPB_W-1:0] cnt, cpb, half;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_BITS-1:0]  sh;
  logic                  armed, p_ok, stop_sample, done;
  logic                  bit_tick, half_tick, last_bit;
  logic                  arm_c, start_c, go_data_c, shift_c, par_cap_c, stop_cap_c;

  assign half      = cpb >> 1;
  assign bit_tick  = (cnt == cpb);
  assign half_tick = (cnt == half);
  assign last_bit  = (bit_idx == IDX_W'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (armed && !line_s)     state_nxt = START;
      START:   if (half_tick)            state_nxt = line_s ? IDLE : DATA;
      DATA:    if (bit_tick && last_bit) state_nxt = PARITY;
      PARITY:  if (bit_tick)             state_nxt = STOP;
      STOP:    if (bit_tick)             state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    arm_c      = 1'b0;
    start_c    = 1'b0;
    go_data_c  = 1'b0;
    shift_c    = 1'b0;
    par_cap_c  = 1'b0;
    stop_cap_c = 1'b0;
    case (state)
      IDLE: begin
        arm_c   = line_s;
        start_c = armed && !line_s;
      end
      START:   go_data_c  = half_tick && !line_s;
      DATA:    shift_c    = bit_tick;
      PARITY:  par_cap_c  = bit_tick;
      STOP:    stop_cap_c = bit_tick;
      default: ;
    endcase
  end

  // A low stop bit disarms start detection until the line has been seen high
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      cpb         <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      armed       <= 1'b0;
      p_ok        <= 1'b0;
      stop_sample <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= stop_cap_c;
      if (start_c) cpb <= clks_per_bit;
      if (start_c || go_data_c || shift_c || par_cap_c || stop_cap_c)
        cnt <= '0;
      else if (state != IDLE)
        cnt <= cnt + UART_CPB_W'(1);
      if (arm_c)                      armed <= 1'b1;
      else if (stop_cap_c && !line_s) armed <= 1'b0;
      if (go_data_c)    bit_idx <= '0;
      else if (shift_c) bit_idx <= bit_idx + IDX_W'(1);
      if (shift_c)    sh          <= {line_s, sh[DATA_BITS-1:1]};
      if (par_cap_c)  p_ok        <= (line_s == uart_parity(UART_DATA_BITS'(sh)));
      if (stop_cap_c) stop_sample <= line_s;
    end
  end

  // Holding register; a completing frame takes priority over a same-cycle ack
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.busy <= (state_nxt != IDLE);
      if (done) begin
        bus.data_out   <= UART_DATA_BITS'(sh);
        bus.parity_err <= !p_ok;
        bus.frame_err  <= !stop_sample;
        bus.data_valid <= 1'b1;
        bus.overrun    <= bus.data_valid && !bus.data_ack;
      end else if (bus.data_ack && bus.data_valid) begin
        bus.data_valid <= 1'b0;
        bus.overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: directed serial frames at 434 clk/bit,
// expected bytes queued at issue time and checked by a concurrent monitor.
module tb_uart_rx_frame;

  localparam int unsigned CPB     = 434;
  localparam int unsigned BIT_CYC = CPB + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_line;
  logic [9:0] cpb_in;

  uart_rx_frame_if ifc ();

  uart_rx_frame #(.DATA_BITS(8), .SYNC_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .UART_line    (uart_line),
    .clks_per_bit (cpb_in),
    .bus          (ifc.master)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_period(input logic v);
    uart_line = v;
    cycles(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
    bit_period(par);
    bit_period(stop);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr,
                              input logic ovr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    e.ovr  = ovr;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!ifc.data_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk1(nm, ifc.data_valid, 1'b1);
  endtask

  task automatic ack_byte(input string nm);
    wait_valid({nm, "_valid"});
    ifc.data_ack = 1'b1;
    @(negedge clk);
    ifc.data_ack = 1'b0;
    chk1({nm, "_ack_valid"},   ifc.data_valid, 1'b0);
    chk1({nm, "_ack_overrun"}, ifc.overrun,    1'b0);
  endtask

  // Pops one expectation per delivered byte: valid rising, overrun rising,
  // or new data replacing an unacknowledged byte.
  task automatic monitor();
    logic       pv = 1'b0;
    logic       po = 1'b0;
    logic [7:0] pd = 8'h00;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst && ((ifc.data_valid && !pv) || (ifc.overrun && !po) ||
                  (ifc.data_valid && pv && ifc.data_out != pd))) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got data=%02h with no frame expected", ifc.data_out);
        end else begin
          e = exp_q.pop_front();
          chk8("frame_data",    ifc.data_out,   e.data);
          chk1("frame_parity",  ifc.parity_err, e.perr);
          chk1("frame_framing", ifc.frame_err,  e.ferr);
          chk1("frame_overrun", ifc.overrun,    e.ovr);
        end
      end
      pv = ifc.data_valid;
      po = ifc.overrun;
      pd = ifc.data_out;
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk8({nm, "_data_out"},   ifc.data_out,   8'h00);
    chk1({nm, "_data_valid"}, ifc.data_valid, 1'b0);
    chk1({nm, "_parity_err"}, ifc.parity_err, 1'b0);
    chk1({nm, "_frame_err"},  ifc.frame_err,  1'b0);
    chk1({nm, "_overrun"},    ifc.overrun,    1'b0);
    chk1({nm, "_busy"},       ifc.busy,       1'b0);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    uart_line    = 1'b1;
    rst          = 1'b0;
    cpb_in       = 10'(CPB);
    ifc.data_ack = 1'b0;
    cycles(5);
    check_all_zero("reset");
    rst = 1'b1;
    cycles(20);

    fork
      monitor();
      begin
        // Clean frame
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1);
        ack_byte("t1");
        cycles(50);
        chk1("t1_busy_idle", ifc.busy, 1'b0);
        chk8("t1_data_held", ifc.data_out, 8'hA5);

        // Bad parity
        expect_frame(8'h01, 1'b1, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1);
        ack_byte("t2");

        // Low stop bit, line held low, then a clean frame
        expect_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (3 * BIT_CYC) begin
          @(negedge clk);
          seen |= ifc.busy;
        end
        chk1("t3_no_spurious_busy", seen, 1'b0);
        ack_byte("t3a");
        uart_line = 1'b1;
        cycles(2 * BIT_CYC);
        expect_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        ack_byte("t3b");

        // Short low glitch on idle line
        uart_line = 1'b0;
        seen = 1'b0;
        repeat (100) begin
          @(negedge clk);
          seen |= ifc.busy;
        end
        uart_line = 1'b1;
        repeat (400) begin
          @(negedge clk);
          seen |= ifc.busy;
        end
        chk1("t4_busy_pulsed",  seen,           1'b1);
        chk1("t4_busy_idle",    ifc.busy,       1'b0);
        chk1("t4_no_valid",     ifc.data_valid, 1'b0);
        chk1("t4_parity_err",   ifc.parity_err, 1'b0);
        chk1("t4_frame_err",    ifc.frame_err,  1'b0);
        chk1("t4_overrun",      ifc.overrun,    1'b0);
        chk8("t4_data_held",    ifc.data_out,   8'h5A);

        // Back-to-back without ack
        expect_frame(8'h11, 1'b0, 1'b0, 1'b0);
        expect_frame(8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        begin
          int n = 0;
          while (!ifc.overrun && n < 3000) begin
            @(negedge clk);
            n++;
          end
        end
        chk1("t5_overrun", ifc.overrun,  1'b1);
        chk8("t5_data",    ifc.data_out, 8'h22);
        ack_byte("t5");

        // Reset during data bit 4 of 0xFF, frame abandoned
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(1'b1);
        cycles(200);
        rst = 1'b0;
        cycles(2);
        check_all_zero("t6_reset");
        rst = 1'b1;
        cycles(2 * BIT_CYC);
        expect_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        ack_byte("t6");
        cycles(50);
      end
    join_any
    disable fork;

    chkn("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
